stream_framer: RTL
==================

// Module: stream_framer
// PURPOSE
//  Transmit end of the serial stream-sync link: packs OUT_SZ-bit words into fixed frames of
//  PATTERN followed by PACK_AMNT data words (WINDOW_SZ bits in total) and sends them MSB-first,
//  one bit per clk. Its output feeds Stream_syncer directly.
//  Sits between the word-level data source and the serial line.
// PARAMETERS
//  WINDOW_SZ   128     frame length in bits
//  PATTERN_SZ  8       sync pattern width
//  PATTERN     8'he8   sync pattern value; first bit sent is PATTERN[PATTERN_SZ-1]
//  OUT_SZ      8       data word width
//  FILL        8'h00   word sent in a data slot that has no data
//  PACK_AMNT = (WINDOW_SZ-PATTERN_SZ)/OUT_SZ is a localparam; a nonzero remainder is an elaboration error
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  reset          in   1       synchronous, active-high reset
//  tx_en          in   1       enable frame generation
//  data_in        in   OUT_SZ  payload word
//  data_in_valid  in   1       data_in holds a word
//  data_in_ready  out  1       slot-load strobe; the word is accepted when valid&&ready
//  stream         out  1       serial output, registered
//  frame_start    out  1       high during the cycle the first PATTERN bit is on stream
//  underrun       out  1       1-cycle pulse when a slot is filled with FILL
// BEHAVIOUR
//  - Reset: stream=0, data_in_ready=0, frame_start=0, underrun=0, state IDLE, bit_cnt=0, stats=0.
//    Reset takes effect mid-frame: the frame is aborted, stream=0 on the next edge, no partial tail is sent.
//  - States: IDLE, PATTERN, DATA. bit_cnt runs 0..WINDOW_SZ-1 and holds the stream position of the current bit.
//  - IDLE: stream=0. If tx_en=1 at edge t, stream=PATTERN MSB from t+1, frame_start=1 in that cycle,
//    and the state moves to PATTERN with bit_cnt=0.
//  - PATTERN: shifts out PATTERN_SZ bits, then moves to DATA. DATA: PACK_AMNT words, OUT_SZ bits each, MSB-first.
//  - Slot load: data_in_ready=1 exactly in cycles with bit_cnt == PATTERN_SZ-1+k*OUT_SZ, k=0..PACK_AMNT-1.
//    ready depends only on state/bit_cnt, never on valid; it is 0 at all other times, including IDLE.
//  - In a load cycle, if valid=1 the word is captured and its MSB appears on stream at the next edge.
//    If valid=0, FILL is loaded and underrun=1 for that one cycle.
//    The frame never shortens or stretches; length is exactly WINDOW_SZ bits.
//  - At bit_cnt==WINDOW_SZ-1:
//    - tx_en=1: next bit is PATTERN MSB (back-to-back, no gap), frame_start pulses, bit_cnt wraps to 0.
//    - tx_en=0: next state is IDLE and stream=0.
//  - tx_en deassertion mid-frame is ignored until the frame ends; the current frame always completes.
//  - Latency: word accepted at edge t -> its bits on stream in cycles t+1 .. t+OUT_SZ.
// CONFIGURATION
//  STREAM_FRAMER_STATS_EN defined: adds output ports frame_cnt[15:0] and underrun_cnt[15:0].
//    - Both saturate at 16'hffff and clear on reset.
//    - frame_cnt increments on each frame_start; underrun_cnt increments on each underrun pulse.
//  Undefined: these ports and their counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package stream_sync_pkg: WINDOW_SZ, PATTERN_SZ, PATTERN, OUT_SZ, PACK_AMNT defaults and the
//    framer_state_e enum {IDLE, PATTERN, DATA}. Shared with Stream_syncer and the benches.
//  - Sub-module stream_piso: OUT_SZ-bit parallel-load, MSB-first shift register (load, shift, q_msb).
//    It is used for both PATTERN and data words.
//  - The top level holds the FSM, bit_cnt, ready/underrun decode and the optional stats.
// TESTING
//  1 Reset, tx_en=1, valid held 1 with data 8'hbc, 4 frames -> stream = 4x{8'he8, 15x8'hbc} MSB-first;
//    frame_start at cycles 0,128,256,384; underrun never 1.
//  2 valid=0 only at slot k=3 of frame 0 -> bits 32..39 of frame 0 are 8'h00; one underrun pulse
//    at bit_cnt=31; next frame starts at 128.
//  3 tx_en dropped at bit_cnt=50 -> frame finishes at bit 127, then stream=0 and ready=0 from 128 on;
//    re-raising tx_en restarts with a fresh PATTERN.
//  4 reset at bit_cnt=70 -> stream=0 next cycle, no further ready pulses; after release with tx_en=1
//    -> PATTERN MSB one cycle later.
//  5 Loopback stream -> Stream_syncer, 4 frames of 8'hbc -> data_valid with data_out=8'hbc from
//    frame 2 onward; in_frame=1 once locked.
//  6 STREAM_FRAMER_STATS_EN: 3 frames with 2 starved slots -> frame_cnt=3, underrun_cnt=2;
//    counters read 0 after reset.

Source files
------------

// File: rtl/stream_sync_pkg.sv
// Shared constants and framer state encoding for the stream-sync link.
// Used by stream_framer, Stream_syncer and their benches.
package stream_sync_pkg;

    localparam int WINDOW_SZ  = 128;
    localparam int PATTERN_SZ = 8;
    localparam logic [PATTERN_SZ-1:0] PATTERN = 8'he8;
    localparam int OUT_SZ     = 8;
    localparam int PACK_AMNT  = (WINDOW_SZ - PATTERN_SZ) / OUT_SZ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PATTERN,
        S_DATA
    } framer_state_e;

endpackage

// File: rtl/stream_piso.sv
// Parallel-load, MSB-first shift register; zeros shift in at the bottom.
module stream_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q_msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign q_msb = sr[W-1];

endmodule

// File: rtl/stream_framer.sv
// Serial framer: PATTERN then PACK_AMNT words per WINDOW_SZ-bit frame, MSB-first.
// Define STREAM_FRAMER_STATS_EN to add saturating frame_cnt/underrun_cnt outputs.
module stream_framer
    import stream_sync_pkg::*;
#(
    parameter int WINDOW_SZ  = stream_sync_pkg::WINDOW_SZ,
    parameter int PATTERN_SZ = stream_sync_pkg::PATTERN_SZ,
    parameter logic [PATTERN_SZ-1:0] PATTERN = stream_sync_pkg::PATTERN,
    parameter int OUT_SZ     = stream_sync_pkg::OUT_SZ,
    parameter logic [OUT_SZ-1:0] FILL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic [OUT_SZ-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic              stream,
    output logic              frame_start,
`ifdef STREAM_FRAMER_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       underrun_cnt,
`endif
    output logic              underrun
);

    localparam int CNT_W = $clog2(WINDOW_SZ);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_SZ - 1);
    localparam logic [CNT_W-1:0] FIRST_SLOT = CNT_W'(PATTERN_SZ - 1);
    localparam logic [OUT_SZ-1:0] PAT_WORD =
        OUT_SZ'(PATTERN) << (OUT_SZ - PATTERN_SZ);

    if ((WINDOW_SZ - PATTERN_SZ) % OUT_SZ != 0) begin : g_bad_window
        $error("frame payload is not a whole number of words");
    end
    if (PATTERN_SZ > OUT_SZ) begin : g_bad_pattern
        $error("pattern does not fit the shift register");
    end

    framer_state_e    state, state_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic             slot;
    logic             load;
    logic [OUT_SZ-1:0] ld_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
        end
    end

    // A slot loads while the last bit of the previous field is on the line.
    always_comb begin
        slot = 1'b0;
        if (state != S_IDLE && bit_cnt >= FIRST_SLOT && bit_cnt < LAST) begin
            slot = ((int'(bit_cnt) - (PATTERN_SZ - 1)) % OUT_SZ) == 0;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        load    = 1'b0;
        ld_word = '0;
        unique case (state)
            S_IDLE: begin
                load = 1'b1;
                if (tx_en) begin
                    state_n = S_PATTERN;
                    cnt_n   = '0;
                    ld_word = PAT_WORD;
                end
            end
            default: begin
                cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST) begin
                    load  = 1'b1;
                    cnt_n = '0;
                    if (tx_en) begin
                        state_n = S_PATTERN;
                        ld_word = PAT_WORD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (slot) begin
                    load    = 1'b1;
                    state_n = S_DATA;
                    ld_word = data_in_valid ? data_in : FILL;
                end
            end
        endcase
    end

    stream_piso #(.W(OUT_SZ)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (1'b1),
        .d     (ld_word),
        .q_msb (stream)
    );

    assign data_in_ready = slot && !reset;
    assign underrun      = data_in_ready && !data_in_valid;
    assign frame_start   = (state == S_PATTERN) && (bit_cnt == '0);

`ifdef STREAM_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            if (frame_start && frame_cnt != 16'hffff) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (underrun && underrun_cnt != 16'hffff) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
